// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the single register-file write port (A3/WD3/WE)
// and shares it between the writeback stage (WB) and a FIFO of
// long-latency-unit (LU) results.
//
// A starvation counter guarantees that a non-empty FIFO wins the port
// after it has lost arbitration STARVE_LIMIT cycles in a row. On that
// cycle WB is stalled.
//
// Optional feature (macro RF_INIT_SWEEP_EN): after reset an INIT state
// writes 0 to x1..x31, one register per cycle, before normal operation.
// When the macro is undefined there is no INIT state and init_busy is 0.
//
// Ports:
//   clk, rst                 core clock, async active-high reset
//   wb_we/wb_rd/wb_data      WB write request
//   wb_stall                 WB not granted, hold WB stable
//   lu_valid/lu_rd/lu_data   LU result (valid/ready handshake)
//   lu_ready                 FIFO can accept an LU result
//   rf_we/rf_a3/rf_wd3       register-file write port
//   pend_mask                bit i set while any FIFO entry targets xi
//   fifo_count               FIFO occupancy
//   init_busy                register-clear sweep in progress
module rf_write_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_we,
  input  logic [4:0]                    wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
  output logic                          wb_stall,
  input  logic                          lu_valid,
  input  logic [4:0]                    lu_rd,
  input  logic [DATA_W-1:0]             lu_data,
  output logic                          lu_ready,
  output logic                          rf_we,
  output logic [4:0]                    rf_a3,
  output logic [DATA_W-1:0]             rf_wd3,
  output logic [31:0]                   pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          init_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // FIFO storage; q_vld tracks occupied slots so pend_mask can be
  // rebuilt from the post-update contents.
  logic [4:0]            q_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0]     q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_vld, vld_nxt;
  logic [4:0]            rd_nxt [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt, starve_nxt;
  logic [31:0]           mask_nxt;

  logic sweep_active;
  logic [4:0] sweep_n;
  logic wb_req, fifo_req, fifo_gnt, wb_gnt, push, pop;

`ifdef RF_INIT_SWEEP_EN
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state, state_nxt;

  // state register; sweep_n is the register being cleared this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_INIT;
      sweep_n <= 5'd1;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) sweep_n <= sweep_n + 5'd1;
    end
  end

  // next state: leave INIT after x31 has been written
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && sweep_n == 5'd31) state_nxt = S_RUN;
  end

  // state-derived outputs
  always_comb begin
    sweep_active = (state == S_INIT);
    init_busy    = sweep_active;
  end
`else
  assign sweep_active = 1'b0;
  assign sweep_n      = 5'd0;
  assign init_busy    = 1'b0;
`endif

  assign wb_req   = wb_we && (wb_rd != 5'd0);
  assign fifo_req = (count != '0);

  // arbitration in RUN; the starvation override beats WB
  always_comb begin
    fifo_gnt = 1'b0;
    wb_gnt   = 1'b0;
    if (!sweep_active) begin
      if (fifo_req && starve_cnt == SW'(STARVE_LIMIT)) fifo_gnt = 1'b1;
      else if (wb_req)                                 wb_gnt   = 1'b1;
      else if (fifo_req)                               fifo_gnt = 1'b1;
    end
  end

  // write-port mux; rst gates everything so a write drops immediately
  always_comb begin
    rf_we    = 1'b0;
    rf_a3    = 5'd0;
    rf_wd3   = '0;
    wb_stall = 1'b0;
    if (!rst) begin
      if (sweep_active) begin
        rf_we    = 1'b1;
        rf_a3    = sweep_n;
        wb_stall = wb_req;
      end else if (fifo_gnt) begin
        rf_we    = 1'b1;
        rf_a3    = q_rd[rd_ptr];
        rf_wd3   = q_data[rd_ptr];
        wb_stall = wb_req;
      end else if (wb_gnt) begin
        rf_we  = 1'b1;
        rf_a3  = wb_rd;
        rf_wd3 = wb_data;
      end
    end
  end

  // lu_ready ignores a same-cycle pop to keep the handshake path short
  assign lu_ready = !rst && !sweep_active && (count < CW'(FIFO_DEPTH));
  // writes to x0 are accepted but dropped
  assign push     = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop      = fifo_gnt;

  // post-update slot contents for the registered pending mask
  always_comb begin
    vld_nxt = q_vld;
    rd_nxt  = q_rd;
    if (pop) vld_nxt[rd_ptr] = 1'b0;
    if (push) begin
      vld_nxt[wr_ptr] = 1'b1;
      rd_nxt[wr_ptr]  = lu_rd;
    end
    mask_nxt = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (vld_nxt[i]) mask_nxt[rd_nxt[i]] = 1'b1;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!fifo_req || fifo_gnt)               starve_nxt = '0;
    else if (starve_cnt != SW'(STARVE_LIMIT)) starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      q_vld      <= '0;
      pend_mask  <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      q_vld      <= vld_nxt;
      pend_mask  <= mask_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // payload needs no reset; q_vld/count qualify it
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= lu_rd;
      q_data[wr_ptr] <= lu_data;
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, lu_valid;
  logic [4:0]  wb_rd, lu_rd;
  logic [31:0] wb_data, lu_data;
  logic        wb_stall, lu_ready, rf_we, init_busy;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3, pend_mask;
  logic [1:0]  fifo_count;

`ifdef RF_INIT_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [36:0] exp_q [$];
  logic [36:0] exp_w;

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .pend_mask(pend_mask), .fifo_count(fifo_count), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", rf_we === 1'b0, rf_we, 0);
      end else begin
        exp_w = exp_q.pop_front();
        chk("rf_write", {rf_a3, rf_wd3} === exp_w, {rf_a3, rf_wd3}, exp_w);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v; lu_rd = rd; lu_data = d;
  endtask

  task automatic expw(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    wb(0, 0, 0);
    lu(0, 0, 0);
    #3;
    chk("rst_rf_we", rf_we === 1'b0, rf_we, 0);
    chk("rst_count", fifo_count === 2'd0, fifo_count, 0);
    chk("rst_pend", pend_mask === 32'h0, pend_mask, 0);
    chk("rst_lu_ready", lu_ready === 1'b0, lu_ready, 0);
    chk("rst_init_busy", init_busy === SWEEP, init_busy, SWEEP);
    nxt();
    rst = 1'b0;

`ifdef RF_INIT_SWEEP_EN
    for (int n = 1; n <= 31; n++) begin
      expw(5'(n), 32'h0);
      @(negedge clk);
      chk("sweep_busy", init_busy === 1'b1, init_busy, 1);
      chk("sweep_lu_ready", lu_ready === 1'b0, lu_ready, 0);
      nxt();
    end
`endif

    wb(1, 5, 32'hDEADBEEF); expw(5, 32'hDEADBEEF);
    @(negedge clk);
    chk("wb_stall0", wb_stall === 1'b0, wb_stall, 0);
    chk("run_init_busy", init_busy === 1'b0, init_busy, 0);
    chk("run_lu_ready", lu_ready === 1'b1, lu_ready, 1);
    nxt();

    wb(1, 6, 32'hA); lu(1, 7, 32'h11); expw(6, 32'hA);
    nxt();
    wb(1, 0, 32'hB); lu(0, 0, 0); expw(7, 32'h11);
    @(negedge clk);
    chk("x0_stall", wb_stall === 1'b0, wb_stall, 0);
    chk("x0_pend7", pend_mask === 32'h80, pend_mask, 32'h80);
    chk("x0_count", fifo_count === 2'd1, fifo_count, 1);
    nxt();
    wb(0, 0, 0);
    @(negedge clk);
    chk("x0_pend_clr", pend_mask === 32'h0, pend_mask, 0);
    chk("x0_count_clr", fifo_count === 2'd0, fifo_count, 0);
    chk("idle_we", rf_we === 1'b0, rf_we, 0);
    nxt();

    wb(1, 10, 32'h100); lu(1, 9, 32'h22); expw(10, 32'h100);
    nxt();
    lu(0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      wb(1, 10, 32'h100 + 32'(k)); expw(10, 32'h100 + 32'(k));
      @(negedge clk);
      chk("starve_wb_stall", wb_stall === 1'b0, wb_stall, 0);
      chk("starve_pend9", pend_mask === 32'h200, pend_mask, 32'h200);
      nxt();
    end
    wb(1, 10, 32'h105); expw(9, 32'h22);
    @(negedge clk);
    chk("starve_stall", wb_stall === 1'b1, wb_stall, 1);
    nxt();
    expw(10, 32'h105);
    @(negedge clk);
    chk("starve_after", wb_stall === 1'b0, wb_stall, 0);
    chk("starve_count", fifo_count === 2'd0, fifo_count, 0);
    nxt();

    wb(0, 0, 0); lu(1, 0, 32'h99);
    @(negedge clk);
    chk("drop_ready", lu_ready === 1'b1, lu_ready, 1);
    nxt();
    lu(0, 0, 0);
    @(negedge clk);
    chk("drop_count", fifo_count === 2'd0, fifo_count, 0);
    nxt();

    wb(1, 11, 32'h200); lu(1, 12, 32'h33); expw(11, 32'h200);
    nxt();
    wb(1, 11, 32'h201); lu(1, 13, 32'h44); expw(11, 32'h201);
    @(negedge clk);
    chk("fill_count1", fifo_count === 2'd1, fifo_count, 1);
    nxt();
    wb(1, 11, 32'h202); lu(1, 14, 32'h55); expw(11, 32'h202);
    @(negedge clk);
    chk("full_count", fifo_count === 2'd2, fifo_count, 2);
    chk("full_ready", lu_ready === 1'b0, lu_ready, 0);
    chk("full_pend", pend_mask === 32'h3000, pend_mask, 32'h3000);
    nxt();
    wb(0, 0, 0); expw(12, 32'h33);
    @(negedge clk);
    chk("pop_ready_hold", lu_ready === 1'b0, lu_ready, 0);
    nxt();
    expw(13, 32'h44);
    @(negedge clk);
    chk("pushpop_ready", lu_ready === 1'b1, lu_ready, 1);
    nxt();
    lu(0, 0, 0); expw(14, 32'h55);
    @(negedge clk);
    chk("pushpop_count", fifo_count === 2'd1, fifo_count, 1);
    chk("pushpop_pend", pend_mask === 32'h4000, pend_mask, 32'h4000);
    nxt();
    @(negedge clk);
    chk("drain_count", fifo_count === 2'd0, fifo_count, 0);
    nxt();

    wb(1, 15, 32'h300); lu(1, 16, 32'h66); expw(15, 32'h300);
    nxt();
    wb(1, 15, 32'h301); lu(1, 17, 32'h77); expw(15, 32'h301);
    nxt();
    wb(1, 15, 32'h302); lu(0, 0, 0); expw(15, 32'h302);
    @(negedge clk);
    chk("pre_rst_count", fifo_count === 2'd2, fifo_count, 2);
    chk("pre_rst_pend", pend_mask === 32'h30000, pend_mask, 32'h30000);
    nxt();
    wb(1, 15, 32'h303);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we", rf_we === 1'b0, rf_we, 0);
    chk("mid_rst_count", fifo_count === 2'd0, fifo_count, 0);
    chk("mid_rst_pend", pend_mask === 32'h0, pend_mask, 0);
    chk("mid_rst_stall", wb_stall === 1'b0, wb_stall, 0);
    wb(0, 0, 0);
    nxt();
    nxt();
    chk("queue_drained", exp_q.size() === 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
